// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with stall hold, bubble insertion and flush
// Optional hold/bubble performance counters are enabled by defining MEMWB_PERF_CNT_EN.
module mem_wb_stage #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               mem_valid,
    input  logic [ADDR_W-1:0]  mem_waddr,
    input  logic               mem_reg_we,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    output logic               wb_valid,
    output logic [ADDR_W-1:0]  wb_waddr,
    output logic               wb_reg_we,
    output logic [DATA_W-1:0]  wb_data,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    generate
        if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("mem_wb_stage: STAGE_IDX must lie in 0..STALL_W-2");
        end
    endgenerate

    logic mem_stall;
    logic wb_stall;
    logic hold;
    logic bubble;
    logic unused_stall_bits;

    assign mem_stall         = stall[STAGE_IDX];
    assign wb_stall          = stall[STAGE_IDX+1];
    assign hold              = mem_stall & wb_stall;
    // A stalled MEM with a running WB must not hand the same instruction over twice.
    assign bubble            = mem_stall & ~wb_stall;
    assign unused_stall_bits = ^stall;

    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            wb_valid  <= 1'b0;
            wb_waddr  <= '0;
            wb_reg_we <= 1'b0;
            wb_data   <= '0;
            wb_whilo  <= 1'b0;
            wb_hi     <= '0;
            wb_lo     <= '0;
        end else if (!hold) begin
            wb_valid  <= mem_valid;
            wb_waddr  <= mem_valid ? mem_waddr : '0;
            wb_reg_we <= mem_reg_we & mem_valid;
            wb_data   <= mem_valid ? mem_data : '0;
            wb_whilo  <= mem_whilo & mem_valid;
            wb_hi     <= mem_valid ? mem_hi : '0;
            wb_lo     <= mem_valid ? mem_lo : '0;
        end
    end

`ifdef MEMWB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Counters track the stall decode only; flush does not touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (hold && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (bubble && bubble_q != '1) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard testbench for mem_wb_stage with directed vectors
module tb_mem_wb_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  waddr;
        logic        reg_we;
        logic [31:0] data;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } wb_t;

    typedef struct {
        string       name;
        wb_t         wb;
        logic        chk_cnt;
        logic [31:0] scnt;
        logic [31:0] bcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    wb_t         mem;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem.valid),
        .mem_waddr  (mem.waddr),
        .mem_reg_we (mem.reg_we),
        .mem_data   (mem.data),
        .mem_whilo  (mem.whilo),
        .mem_hi     (mem.hi),
        .mem_lo     (mem.lo),
        .wb_valid   (wb_valid),
        .wb_waddr   (wb_waddr),
        .wb_reg_we  (wb_reg_we),
        .wb_data    (wb_data),
        .wb_whilo   (wb_whilo),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_t mk(input logic v, input logic [4:0] wa, input logic we,
                               input logic [31:0] d, input logic wh,
                               input logic [31:0] hi, input logic [31:0] lo);
        wb_t t;
        t.valid = v; t.waddr = wa; t.reg_we = we; t.data = d;
        t.whilo = wh; t.hi = hi; t.lo = lo;
        return t;
    endfunction

    task automatic step(input string name, input logic r, input logic f, input logic [5:0] s,
                        input wb_t m, input wb_t e, input logic chk = 1'b0,
                        input int sc = 0, input int bc = 0);
        exp_t x;
        @(negedge clk);
        rst = r; flush = f; stall = s; mem = m;
        x.name = name; x.wb = e; x.chk_cnt = chk;
`ifdef MEMWB_PERF_CNT_EN
        x.scnt = 32'(sc); x.bcnt = 32'(bc);
`else
        x.scnt = 32'd0; x.bcnt = 32'd0;
`endif
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    // Monitor: the stage presents a new result after every edge, so pop one expectation per edge.
    initial begin
        exp_t e;
        wb_t  got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {wb_valid, wb_waddr, wb_reg_we, wb_data, wb_whilo, wb_hi, wb_lo};
                n_checks++;
                if (got !== e.wb) begin
                    n_fails++;
                    $display("FAIL %s: wb got v=%b a=%0d we=%b d=%h whilo=%b hi=%h lo=%h, expected v=%b a=%0d we=%b d=%h whilo=%b hi=%h lo=%h",
                             e.name, got.valid, got.waddr, got.reg_we, got.data, got.whilo, got.hi, got.lo,
                             e.wb.valid, e.wb.waddr, e.wb.reg_we, e.wb.data, e.wb.whilo, e.wb.hi, e.wb.lo);
                end
                if (e.chk_cnt) begin
                    n_checks++;
                    if (stall_cnt !== e.scnt || bubble_cnt !== e.bcnt) begin
                        n_fails++;
                        $display("FAIL %s_cnt: got stall_cnt=%0d bubble_cnt=%0d, expected %0d %0d",
                                 e.name, stall_cnt, bubble_cnt, e.scnt, e.bcnt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_t z;
        wb_t m;
        z     = '0;
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b0;
        mem   = mk(1'b1, 5'd31, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hAAAA, 32'hBBBB);

        step("reset0", 1'b1, 1'b0, 6'b0, mem, z, 1'b1, 0, 0);
        step("reset1", 1'b1, 1'b0, 6'b0, mem, z);
        m = mk(1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
        step("first", 1'b0, 1'b0, 6'b0, m, m);

        for (int i = 1; i <= 4; i++) begin
            m = mk(1'b1, 5'(i), 1'b1, 32'(i * 32'h11), 1'b0, 32'h0, 32'h0);
            step("stream", 1'b0, 1'b0, 6'b0, m, m);
        end

        m = mk(1'b1, 5'd7, 1'b1, 32'h77, 1'b0, 32'h0, 32'h0);
        step("load7", 1'b0, 1'b0, 6'b0, m, m);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 6'b110000,
                 mk(1'b1, 5'(8 + i), 1'b1, 32'(32'h80 + i), 1'b1, 32'h5, 32'h6),
                 m, i == 2, 3, 0);
        end

        m = mk(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0);
        step("bubble", 1'b0, 1'b0, 6'b010000, m, z, 1'b1, 3, 1);
        step("release", 1'b0, 1'b0, 6'b0, m, m);
        step("once", 1'b0, 1'b0, 6'b0, mk(1'b0, 5'd9, 1'b1, 32'h99, 1'b1, 32'h3, 32'h4), z);

        m = mk(1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 32'h0, 32'h0);
        step("stall_violation", 1'b0, 1'b0, 6'b100000, m, m);
        m = mk(1'b1, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0, 32'h0);
        step("other_bits", 1'b0, 1'b0, 6'b001111, m, m, 1'b1, 3, 1);
        m = mk(1'b1, 5'd0, 1'b1, 32'h55, 1'b0, 32'h0, 32'h0);
        step("r0_write", 1'b0, 1'b0, 6'b0, m, m);

        step("flush_hold", 1'b0, 1'b1, 6'b110000, mk(1'b1, 5'd4, 1'b1, 32'h44, 1'b0, 32'h0, 32'h0), z);
        m = mk(1'b1, 5'd12, 1'b1, 32'h1234, 1'b1, 32'h9, 32'hA);
        step("reload", 1'b0, 1'b0, 6'b0, m, m);
        step("flush", 1'b0, 1'b1, 6'b0, m, z);
        step("reload2", 1'b0, 1'b0, 6'b0, m, m);
        step("rst_flush", 1'b1, 1'b1, 6'b110000, m, z, 1'b1, 0, 0);

        m = mk(1'b1, 5'd6, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2);
        step("hilo", 1'b0, 1'b0, 6'b0, m, m);
        step("hilo_invalid", 1'b0, 1'b0, 6'b0, mk(1'b0, 5'd6, 1'b1, 32'h66, 1'b1, 32'h1, 32'h2), z);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
